// File: rtl/ADDER.sv
// 4-bit ripple-carry adder shared across the arithmetic blocks.
// The carry chain runs LSB to MSB, one full-adder stage per bit.
module ADDER (
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       CI,
   output logic [3:0] S,
   output logic       CO
);

   always_comb begin
      logic c;
      S = '0;
      c = CI;
      for (int i = 0; i < 4; i++) begin
         S[i] = A[i] ^ B[i] ^ c;
         c    = (A[i] & B[i]) | (c & (A[i] ^ B[i]));
      end
      CO = c;
   end

endmodule

// File: rtl/mul_sequencer.sv
// Sequential 4x4 unsigned shift-and-add multiplier over one shared ADDER.
// Four CALC iterations, then a one-cycle FIN that pulses DONE with P updated.
module mul_sequencer (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       START,
   input  logic [3:0] A,
   input  logic [3:0] B,
   output logic       BUSY,
   output logic       DONE,
   output logic [7:0] P
);

   typedef enum logic [1:0] {StIdle, StCalc, StFin} state_e;

   state_e     state_q, state_d;
   logic [3:0] mcand_q, mcand_d;
   logic [3:0] acc_q, acc_d;
   logic [3:0] mq_q, mq_d;
   logic [1:0] cnt_q, cnt_d;
   logic [7:0] p_q, p_d;

   logic [3:0] add_s;
   logic       add_co;
   logic       c;
   logic [3:0] s;

   ADDER u_adder (
      .A  (acc_q),
      .B  (mcand_q),
      .CI (1'b0),
      .S  (add_s),
      .CO (add_co)
   );

   // Partial sum for this iteration: add the multiplicand only when mq[0] is set.
   always_comb begin
      c = mq_q[0] & add_co;
      s = mq_q[0] ? add_s : acc_q;
   end

   always_comb begin
      state_d = state_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      mq_d    = mq_q;
      cnt_d   = cnt_q;
      p_d     = p_q;
      unique case (state_q)
         StIdle: begin
            if (START) begin
               mcand_d = A;
               mq_d    = B;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = StCalc;
            end
         end
         StCalc: begin
            {acc_d, mq_d} = {c, s, mq_q[3:1]};
            // 2-bit increment kept off the arithmetic path: only ADDER may add.
            cnt_d = {cnt_q[1] ^ cnt_q[0], ~cnt_q[0]};
            if (cnt_q == 2'd3) begin
               p_d     = {c, s, mq_q[3:1]};
               state_d = StFin;
            end
         end
         StFin: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= StIdle;
         mcand_q <= '0;
         acc_q   <= '0;
         mq_q    <= '0;
         cnt_q   <= '0;
         p_q     <= '0;
      end else begin
         state_q <= state_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         mq_q    <= mq_d;
         cnt_q   <= cnt_d;
         p_q     <= p_d;
      end
   end

   assign BUSY = (state_q != StIdle);
   assign DONE = (state_q == StFin);
   assign P    = p_q;

endmodule
